serial_reg_responder: RTL
=========================

# serial_reg_responder

Serial target for the FLASH-style serial link. It sits at the far end of the byte-serial master used on the board: it receives FCK, data and chip-select, decodes a command byte, and performs single-cycle reads and writes on a 128 x 8 register port. It is written for the main FPGA side, where on-board control registers are reached over the serial link instead of the VME bus.

## Interface
- SYNC_STAGES, 2: synchronizer depth on NCS, FCK and SDI (minimum 2).
- CLK  in  1  system clock, 125 MHz.
- NRST  in  1  synchronous reset, active-low.
- NCS  in  1  frame select from master, active-low, asynchronous to CLK.
- FCK  in  1  serial clock from master, idle high, asynchronous to CLK.
- SDI  in  1  serial data from master, MSB first.
- SDO  out  1  serial data to master, MSB first.
- SDOE  out  1  SDO output enable.
- REG_ADDR  out  7  register address.
- REG_WDATA  out  8  write data.
- REG_WE  out  1  one-cycle write strobe.
- REG_RE  out  1  one-cycle read strobe.
- REG_RDATA  in  8  read data; valid on the cycle after REG_RE.
- BUSY  out  1  high while a frame is active.
- ERR  out  1  one-cycle pulse when a frame is aborted mid-byte.

## Operation
- Mode: FCK idles high. The master changes data on FCK falling edges and samples on rising edges. The responder samples SDI on each rising edge of synchronized FCK and updates SDO on each falling edge.
- Frame: NCS falls, then a command byte, then one or more data bytes, then NCS rises.
- Command byte: bit 7 = 1 for read, 0 for write. Bits 6:0 are the start address.
- States:
  - IDLE: waiting for NCS low.
  - CMD: shifting in the command byte.
  - RD: serving read data bytes.
  - WR: receiving write data bytes.
- A 3-bit bit counter counts rising edges and wraps 7 -> 0 at each byte boundary.
- IDLE -> CMD on synchronized NCS low. BUSY goes high.
- CMD -> RD or WR at the 8th rising edge. REG_ADDR is loaded from bits 6:0.
- Read path:
  - REG_RE pulses on the cycle after the 8th rising edge.
  - REG_RDATA is captured into the output shift register on the next cycle.
  - Bit 7 drives SDO at the next falling edge.
  - After each 8th rising edge in RD: REG_ADDR increments, then REG_RE and capture repeat.
  - SDI is ignored in RD.
- Write path:
  - At each 8th rising edge in WR: the shifted byte goes to REG_WDATA and REG_WE pulses for one cycle at the current REG_ADDR.
  - REG_ADDR increments on the cycle after REG_WE.
- Address wraps 127 -> 0.
- SDOE is high only in RD. SDO = 1 whenever SDOE is low.
- Synchronized NCS high in any state forces IDLE. BUSY goes low.
  - If the bit counter is not 0: ERR pulses for one cycle and no REG_WE is issued for the partial byte.
  - A completed byte's REG_WE is never cancelled.
- A FCK edge and NCS rising detected in the same cycle: NCS wins and the edge is ignored.
- Reset (NRST low at a CLK edge): state IDLE, counters 0, REG_ADDR = 0, REG_WDATA = 0, REG_WE = REG_RE = BUSY = ERR = SDOE = 0, SDO = 1. Reset mid-frame gives the same result; the remainder of the frame is ignored until NCS goes high and then low again.

## Timing
- Input latency: SYNC_STAGES cycles to synchronize, plus 1 cycle to detect an edge.
- FCK high and low phases must each be at least SYNC_STAGES + 3 CLK cycles. Required FCK ≤ CLK/10 (12.5 MHz).
- Read data: SDO is valid SYNC_STAGES + 2 CLK cycles after the FCK falling edge. This is before the next rising edge under the rule above.
- REG_WE occurs SYNC_STAGES + 2 cycles after the 8th FCK rising edge of a data byte.
- REG_RE occurs SYNC_STAGES + 2 cycles after the 8th FCK rising edge of the preceding byte.
- NCS low must precede the first FCK fall by at least SYNC_STAGES + 2 cycles.

## Structure
- Package serial_reg_pkg:
  - state encoding (IDLE, CMD, RD, WR);
  - CMD_READ_BIT = 7;
  - ADDR_W = 7, DATA_W = 8.
- Sub-module sync_edge: an N-stage synchronizer with rise and fall pulse outputs. It is instantiated for FCK and NCS; SDI uses the synchronizer only.

## Test plan
- Write frame: command 0x05, data 0xA7, FCK = CLK/10 -> one REG_WE, REG_ADDR = 0x05, REG_WDATA = 0xA7, ERR = 0.
- Burst write: command 0x7F, data 0x11, 0x22 -> REG_WE at 0x7F with 0x11, then at 0x00 with 0x22.
- Burst read:
  - Stimulus: command 0x83; REG_RDATA model returns 0x3C for address 0x03 and 0xC3 for address 0x04.
  - Required: master receives 0x3C then 0xC3; SDOE is low during the command byte.
- Abort: NCS rises after 5 data bits of a write -> ERR pulses once, no REG_WE, BUSY falls, next frame decodes normally.
- Reset: NRST pulsed low in the middle of a read byte -> SDO = 1, SDOE = 0, BUSY = 0; no strobes until the next NCS fall.
- Idle noise: FCK toggling while NCS is high -> no strobes, BUSY stays 0.

Source files
------------

// File: rtl/serial_reg_pkg.sv
// Shared types and constants for the serial register responder.
package serial_reg_pkg;

  localparam int unsigned ADDR_W       = 7;
  localparam int unsigned DATA_W       = 8;
  localparam int unsigned CMD_READ_BIT = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_RD   = 2'd2,
    ST_WR   = 2'd3
  } state_e;

endpackage

// File: rtl/sync_edge.sv
// N-stage synchronizer for an asynchronous input with single-cycle rise/fall pulses.
module sync_edge #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b1
) (
  input  logic CLK,
  input  logic NRST,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  always_ff @(posedge CLK) begin
    if (!NRST) begin
      chain <= {STAGES{RST_VAL}};
      prev  <= RST_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      prev  <= chain[STAGES-1];
    end
  end

  assign rise = chain[STAGES-1] & ~prev;
  assign fall = ~chain[STAGES-1] & prev;

endmodule

// File: rtl/serial_reg_responder.sv
// Serial-link target: decodes a command byte and performs burst reads/writes
// on a 128 x 8 register port.
module serial_reg_responder
  import serial_reg_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              CLK,
  input  logic              NRST,
  input  logic              NCS,
  input  logic              FCK,
  input  logic              SDI,
  output logic              SDO,
  output logic              SDOE,
  output logic [ADDR_W-1:0] REG_ADDR,
  output logic [DATA_W-1:0] REG_WDATA,
  output logic              REG_WE,
  output logic              REG_RE,
  input  logic [DATA_W-1:0] REG_RDATA,
  output logic              BUSY,
  output logic              ERR
);

  state_e state, state_d;

  logic fck_rise, fck_fall, ncs_rise, ncs_fall;
  logic [SYNC_STAGES-1:0] sdi_chain;
  logic sdi_s;

  logic [2:0]        bitcnt;
  logic [DATA_W-2:0] shift_in;
  logic [DATA_W-1:0] rx_byte;
  logic [DATA_W-1:0] tx_shift;
  logic              sdo_q;
  logic              we_pend, re_pend, cap_pend;
  logic              err_d, byte_done;

  // NCS chain resets to "selected" so a reset inside a frame yields no fall
  // edge: the frame is ignored until NCS is seen high and then low again.
  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_ncs_sync (
    .CLK  (CLK),
    .NRST (NRST),
    .din  (NCS),
    .rise (ncs_rise),
    .fall (ncs_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_fck_sync (
    .CLK  (CLK),
    .NRST (NRST),
    .din  (FCK),
    .rise (fck_rise),
    .fall (fck_fall)
  );

  always_ff @(posedge CLK) begin
    if (!NRST) sdi_chain <= '0;
    else       sdi_chain <= {sdi_chain[SYNC_STAGES-2:0], SDI};
  end
  assign sdi_s = sdi_chain[SYNC_STAGES-1];

  assign rx_byte   = {shift_in, sdi_s};
  assign byte_done = (state != ST_IDLE) && fck_rise && !ncs_rise && (bitcnt == 3'd7);

  always_ff @(posedge CLK) begin
    if (!NRST) state <= ST_IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    err_d   = 1'b0;
    unique case (state)
      ST_IDLE: if (ncs_fall) state_d = ST_CMD;
      ST_CMD: begin
        if (ncs_rise) begin
          state_d = ST_IDLE;
          err_d   = (bitcnt != 3'd0);
        end else if (byte_done) begin
          state_d = rx_byte[CMD_READ_BIT] ? ST_RD : ST_WR;
        end
      end
      ST_RD, ST_WR: begin
        if (ncs_rise) begin
          state_d = ST_IDLE;
          err_d   = (bitcnt != 3'd0);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Strobe pipeline (pend -> strobe -> addr-increment/capture) runs on its own
  // so a completed byte's write still issues if NCS rises right after it.
  always_ff @(posedge CLK) begin
    if (!NRST) begin
      bitcnt    <= '0;
      shift_in  <= '0;
      tx_shift  <= '0;
      sdo_q     <= 1'b1;
      we_pend   <= 1'b0;
      re_pend   <= 1'b0;
      cap_pend  <= 1'b0;
      REG_WE    <= 1'b0;
      REG_RE    <= 1'b0;
      REG_ADDR  <= '0;
      REG_WDATA <= '0;
      ERR       <= 1'b0;
    end else begin
      ERR      <= err_d;
      we_pend  <= 1'b0;
      re_pend  <= 1'b0;
      REG_WE   <= we_pend;
      REG_RE   <= re_pend;
      cap_pend <= REG_RE;

      if (REG_WE)   REG_ADDR <= REG_ADDR + 1'b1;
      if (cap_pend) tx_shift <= REG_RDATA;

      if (state != ST_IDLE && fck_rise && !ncs_rise) begin
        bitcnt   <= bitcnt + 3'd1;
        shift_in <= rx_byte[DATA_W-2:0];
      end
      if (state_d == ST_IDLE) bitcnt <= '0;

      if (byte_done) begin
        unique case (state)
          ST_CMD: begin
            REG_ADDR <= rx_byte[ADDR_W-1:0];
            sdo_q    <= 1'b1;
            re_pend  <= rx_byte[CMD_READ_BIT];
          end
          ST_WR: begin
            REG_WDATA <= rx_byte;
            we_pend   <= 1'b1;
          end
          ST_RD: begin
            REG_ADDR <= REG_ADDR + 1'b1;
            re_pend  <= 1'b1;
          end
          default: ;
        endcase
      end

      if (state == ST_RD && fck_fall && !ncs_rise) begin
        sdo_q    <= tx_shift[DATA_W-1];
        tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
      end
    end
  end

  assign SDOE = (state == ST_RD);
  assign SDO  = SDOE ? sdo_q : 1'b1;
  assign BUSY = (state != ST_IDLE);

endmodule
